// File: rtl/scan_chain_autocheck.sv
// Scan-chain self-checker: flushes NCH chains, injects one token per chain every PERIOD cycles
// for ROUNDS rounds, and checks each tail at the exact arrival cycle. Optional: SC_AUTOCHECK_FIRST_ERR_EN.
module scan_chain_autocheck #(
   parameter int NCH    = 4,
   parameter int LEN_W  = 16,
   parameter int PERIOD = 128,
   parameter int ROUNDS = 4,
   parameter int ERR_W  = 8,
   localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
   input  logic                   clk,
   input  logic                   Reset_n,
   input  logic                   start,
   input  logic [LEN_W-1:0]       chain_len,
   input  logic [NCH-1:0]         sc_tail,
   output logic [NCH-1:0]         sc_head,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic                   cfg_err,
   output logic [NCH-1:0]         fail_mask,
   output logic [NCH*ERR_W-1:0]   err_cnt
`ifdef SC_AUTOCHECK_FIRST_ERR_EN
   ,
   output logic                   first_err_vld,
   output logic [CH_W-1:0]        first_err_ch,
   output logic [RND_W-1:0]       first_err_round
`endif
);

   localparam int PH_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PERIOD - 1);
   localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);
   localparam logic [LEN_W:0]   PERIOD_L = (LEN_W + 1)'(PERIOD);
   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RUN, S_DONE} state_t;

   state_t           state;
   logic [PH_W-1:0]  len_q;
   logic [PH_W-1:0]  phase;
   logic [RND_W-1:0] round;
   logic             len_bad;
   logic             exp_bit;
   logic [NCH-1:0]   mismatch;
   logic [NCH-1:0]   fail_nxt;

   // A legal length always fits in the phase counter, so the flush reuses it.
   always_comb begin
      len_bad  = (chain_len == '0) || ({1'b0, chain_len} >= PERIOD_L);
      exp_bit  = (phase == len_q);
      mismatch = '0;
      for (int i = 0; i < NCH; i++) begin
         // X/Z on a tail must never look like a match.
         mismatch[i] = (sc_tail[i] !== exp_bit);
      end
      fail_nxt = fail_mask | mismatch;
   end

`ifdef SC_AUTOCHECK_FIRST_ERR_EN
   logic [CH_W-1:0] first_idx;

   always_comb begin
      first_idx = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (mismatch[i]) first_idx = CH_W'(i);
      end
   end
`endif

   // NOTE: every register, counters included, is cleared by the async reset so an aborted run leaves nothing behind.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= S_IDLE;
         len_q     <= '0;
         phase     <= '0;
         round     <= '0;
         sc_head   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         cfg_err   <= 1'b0;
         fail_mask <= '0;
         err_cnt   <= '0;
`ifdef SC_AUTOCHECK_FIRST_ERR_EN
         first_err_vld   <= 1'b0;
         first_err_ch    <= '0;
         first_err_round <= '0;
`endif
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  len_q     <= chain_len[PH_W-1:0];
                  err_cnt   <= '0;
                  fail_mask <= '0;
                  pass      <= 1'b0;
                  phase     <= '0;
                  round     <= '0;
`ifdef SC_AUTOCHECK_FIRST_ERR_EN
                  first_err_vld   <= 1'b0;
                  first_err_ch    <= '0;
                  first_err_round <= '0;
`endif
                  if (len_bad) begin
                     cfg_err <= 1'b1;
                     done    <= 1'b1;
                     state   <= S_DONE;
                  end else begin
                     cfg_err <= 1'b0;
                     done    <= 1'b0;
                     busy    <= 1'b1;
                     state   <= S_FLUSH;
                  end
               end
            end
            S_FLUSH: begin
               if (phase == len_q - PH_W'(1)) begin
                  phase   <= '0;
                  round   <= '0;
                  sc_head <= '1;
                  state   <= S_RUN;
               end else begin
                  phase <= phase + PH_W'(1);
               end
            end
            S_RUN: begin
               fail_mask <= fail_nxt;
               for (int i = 0; i < NCH; i++) begin
                  if (mismatch[i] && (err_cnt[i*ERR_W +: ERR_W] != ERR_MAX))
                     err_cnt[i*ERR_W +: ERR_W] <= err_cnt[i*ERR_W +: ERR_W] + ERR_W'(1);
               end
`ifdef SC_AUTOCHECK_FIRST_ERR_EN
               if (|mismatch && !first_err_vld) begin
                  first_err_vld   <= 1'b1;
                  first_err_ch    <= first_idx;
                  first_err_round <= round;
               end
`endif
               if (phase == PH_LAST) begin
                  phase <= '0;
                  if (round == RND_LAST) begin
                     sc_head <= '0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     pass    <= ~|fail_nxt;
                     state   <= S_DONE;
                  end else begin
                     round   <= round + RND_W'(1);
                     sc_head <= '1;
                  end
               end else begin
                  phase   <= phase + PH_W'(1);
                  sc_head <= '0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
